// File: rtl/seg_pkg.sv
// Shared types and helpers for the 7-segment scan controller.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  // Widest display word the nibble helper can address (digits).
  localparam int MAX_DIG = 16;

  typedef enum logic {PH_BLANK, PH_DRIVE} phase_t;

  function automatic logic [3:0] get_nibble(input logic [4*MAX_DIG-1:0] data,
                                            input int unsigned idx);
    return data[4*idx +: 4];
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_dec.sv
// Hex to 7-segment decoder, gfedcba, active low.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h18;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl_timer.sv
// Slot/digit counters: cnt runs 0..DIV-1, idx advances on each slot wrap.
module scan_timer #(
  parameter int NDIG = 4,
  parameter int DIV  = 1024,
  localparam int CW  = $clog2(DIV),
  localparam int IW  = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic [CW-1:0] cnt,
  output logic [IW-1:0] idx,
  output logic          slot_wrap,
  output logic          frame_wrap
);

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;

  always_comb begin
    slot_wrap  = (cnt_q == CNT_LAST);
    frame_wrap = slot_wrap && (idx_q == IDX_LAST);
    cnt_d      = slot_wrap ? '0 : cnt_q + CW'(1);
    idx_d      = idx_q;
    if (slot_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign cnt = cnt_q;
  assign idx = idx_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-synchronous
// double-buffered display word and per-slot anti-ghosting blanking.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NDIG  = 4,
  parameter int DIV   = 1024,
  parameter int BLANK = 16,
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [4*NDIG-1:0] load_data,
  input  logic [NDIG-1:0]   digit_en,
  output logic [6:0]        seg,
  output logic [NDIG-1:0]   anode,
  output logic [IW-1:0]     digit_sel,
  output logic              frame_done
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK);

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          slot_wrap;
  logic          frame_wrap;

  scan_timer #(.NDIG(NDIG), .DIV(DIV)) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .cnt        (cnt),
    .idx        (idx),
    .slot_wrap  (slot_wrap),
    .frame_wrap (frame_wrap)
  );

  logic [4*NDIG-1:0] active_q, active_d;
  logic [4*NDIG-1:0] pending_q, pending_d;
  logic              pend_full_q, pend_full_d;
  logic [6:0]        seg_q, seg_d;
  logic [NDIG-1:0]   anode_q, anode_d;
  logic [IW-1:0]     digit_sel_q, digit_sel_d;
  logic              frame_done_q, frame_done_d;

  phase_t     phase;
  logic [3:0] nibble;
  logic [6:0] seg_dec;
  logic       drive;

  assign nibble = get_nibble((4*MAX_DIG)'(active_q), int'(idx));

  seg_decoder u_dec (
    .hex (nibble),
    .seg (seg_dec)
  );

  always_comb begin
    phase       = (cnt < BLANK_C) ? PH_BLANK : PH_DRIVE;
    active_d    = active_q;
    pending_d   = pending_q;
    pend_full_d = pend_full_q;
    // Transfer and accept are exclusive: accept needs pend_full_q low.
    if (frame_wrap && pend_full_q) begin
      active_d    = pending_q;
      pend_full_d = 1'b0;
    end else if (load_valid && !pend_full_q) begin
      pending_d   = load_data;
      pend_full_d = 1'b1;
    end

    drive        = (phase == PH_DRIVE) && digit_en[idx];
    anode_d      = drive ? ~(NDIG'(1) << idx) : '1;
    seg_d        = drive ? seg_dec : SEG_BLANK;
    digit_sel_d  = idx;
    frame_done_d = frame_wrap;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q     <= '0;
      pending_q    <= '0;
      pend_full_q  <= 1'b0;
      seg_q        <= SEG_BLANK;
      anode_q      <= '1;
      digit_sel_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      active_q     <= active_d;
      pending_q    <= pending_d;
      pend_full_q  <= pend_full_d;
      seg_q        <= seg_d;
      anode_q      <= anode_d;
      digit_sel_q  <= digit_sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign load_ready = !pend_full_q;
  assign seg        = seg_q;
  assign anode      = anode_q;
  assign digit_sel  = digit_sel_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a position-based frame model predicts
// every output cycle; a negedge monitor pops and compares.
module tb_seg_scan_ctrl;

  localparam int NDIG  = 4;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = NDIG * DIV;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_data = '0;
  logic [3:0]  digit_en = 4'hF;
  logic [6:0]  seg;
  logic [3:0]  anode;
  logic [1:0]  digit_sel;
  logic        frame_done;

  seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .BLANK(BLANK)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .digit_en   (digit_en),
    .seg        (seg),
    .anode      (anode),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] anode;
    logic [6:0] seg;
    logic [1:0] sel;
    logic       fd;
    logic       rdy;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [6:0]  dec_tab [16];
  int          cyc;
  logic [15:0] m_active, m_pending;
  bit          m_full, m_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("anode", anode, e.anode);
      check("seg", seg, e.seg);
      check("digit_sel", digit_sel, e.sel);
      check("frame_done", frame_done, e.fd);
      check("load_ready", load_ready, e.rdy);
      check("anode_onehot_low", ($countones(~anode) <= 1), 1);
    end
  end

  // One clock of stimulus; expectation derived from frame position and words.
  task automatic tick(input bit v, input logic [15:0] d, input logic [3:0] en);
    exp_t e;
    int   p, slot, off;
    bit   drv;
    load_valid = v;
    load_data  = d;
    digit_en   = en;
    @(posedge clk);
    p    = cyc % FRAME;
    slot = p / DIV;
    off  = p % DIV;
    drv  = (off >= BLANK) && en[slot];
    e.anode = drv ? ~(4'b0001 << slot) : 4'hF;
    e.seg   = drv ? dec_tab[m_active[4*slot +: 4]] : 7'h7F;
    e.sel   = 2'(slot);
    e.fd    = (p == FRAME - 1);
    m_acc   = 1'b0;
    if (p == FRAME - 1 && m_full) begin
      m_active = m_pending;
      m_full   = 1'b0;
      $display("frame %0d: word %h now displayed", cyc / FRAME, m_active);
    end else if (v && !m_full) begin
      m_pending = d;
      m_full    = 1'b1;
      m_acc     = 1'b1;
      $display("cycle %0d: load accepted data=%h", cyc + 1, d);
    end
    e.rdy = !m_full;
    sb_q.push_back(e);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("rst_anode", anode, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_digit_sel", digit_sel, 2'd0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_load_ready", load_ready, 1'b1);
    sb_q.delete();
    cyc = 0;
    m_full = 1'b0;
    m_active = '0;
    m_pending = '0;
    load_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_anode", anode, 4'hF);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 16'h0, 4'hF);
  endtask

  initial begin
    int guard;
    logic [15:0] w;
    dec_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    cyc = 0;
    m_full = 1'b0;
    m_active = '0;
    m_pending = '0;

    do_reset();

    // Load on first cycle; visible only after the frame boundary.
    tick(1'b1, 16'h3A5F, 4'hF);
    idle(2 * FRAME + 6);

    // Held valid: second word must wait for the first to transfer.
    for (int k = 0; k < 2; k++) begin
      w = (k == 0) ? 16'h1111 : 16'h2222;
      guard = 0;
      do begin
        tick(1'b1, w, 4'hF);
        guard++;
      end while (!m_acc && guard < 200);
      check("held_load_accepted", m_acc, 1'b1);
    end
    idle(3 * FRAME);

    // Load offered exactly on the boundary cycle with an empty buffer.
    guard = 0;
    while (!((cyc % FRAME == FRAME - 1) && !m_full) && guard < 200) begin
      idle(1);
      guard++;
    end
    check("boundary_reached", (cyc % FRAME == FRAME - 1) && !m_full, 1'b1);
    tick(1'b1, 16'h4C7E, 4'hF);
    idle(2 * FRAME + 3);

    // Digits 1 and 3 disabled.
    tick(1'b1, 16'h8888, 4'b0101);
    for (int i = 0; i < 3 * FRAME; i++) tick(1'b0, 16'h0, 4'b0101);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 3) == 0), 16'($urandom),
           ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom));
    end

    // Mid-frame reset with a pending word that must be discarded.
    guard = 0;
    while (!m_full && guard < 100) begin
      tick(1'b1, 16'hBEEF, 4'hF);
      guard++;
    end
    idle(5);
    do_reset();
    idle(2 * FRAME + 4);

    @(negedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
